// File: rtl/rpi_pixel_sampler_if.sv
// Bundles the RPi-side inputs and DAC-side outputs of the pixel sampler.
// The master side drives mode and raw RPi signals; the slave side is the sampler.
interface rpi_pixel_sampler_if #(
  parameter int IN_BITS = 3
);
  logic [1:0]         mode;
  logic               rpi_h_sync;
  logic               rpi_v_sync;
  logic [IN_BITS-1:0] rpi_color;
  logic               h_sync;
  logic               v_sync;
  logic [3:0]         r_out;
  logic [3:0]         g_out;
  logic [3:0]         b_out;
  logic               sample_strobe;

  modport master (
    output mode, rpi_h_sync, rpi_v_sync, rpi_color,
    input  h_sync, v_sync, r_out, g_out, b_out, sample_strobe
  );

  modport slave (
    input  mode, rpi_h_sync, rpi_v_sync, rpi_color,
    output h_sync, v_sync, r_out, g_out, b_out, sample_strobe
  );
endinterface

// File: rtl/rpi_pixel_sampler.sv
// Samples asynchronous RPi video into the clk domain once per pixel period and
// drives 4-bit DAC levels, with mono, RGB111, colour-bar and black modes.
module rpi_pixel_sampler #(
  parameter int         IN_BITS      = 3,
  parameter int         DIV_LOG2     = 3,
  parameter int         SAMPLE_PHASE = 4,
  parameter logic       SYNC_ACT     = 1'b0,
  parameter logic [3:0] ON_LEVEL     = 4'hF,
  parameter int         BAR_LOG2     = 5
) (
  input  logic clk,
  input  logic rst,
  rpi_pixel_sampler_if.slave io_pix
);
  localparam logic                SYNC_INACT = ~SYNC_ACT;
  localparam logic [DIV_LOG2-1:0] PH_ONE     = DIV_LOG2'(1);
  localparam logic [DIV_LOG2-1:0] PH_SAMPLE  = DIV_LOG2'(SAMPLE_PHASE);
  localparam logic [10:0]         PIX_MAX    = 11'h7FF;

  logic               r_hs_meta, r_hs_s, r_hs_d;
  logic               r_vs_meta, r_vs_s;
  logic [IN_BITS-1:0] r_col_meta, r_col_s, r_col_hold;
  logic [DIV_LOG2-1:0] r_phase;
  logic [10:0]        r_pix_cnt;
  logic [3:0]         r_r_out, r_g_out, r_b_out;
  logic               r_strobe_out, r_h_out, r_v_out;

  logic               w_hs_edge, w_strobe, w_blank;
  logic [2:0]         w_col3, w_bar;
  logic [3:0]         w_r, w_g, w_b;

  assign w_hs_edge = (r_hs_s == SYNC_ACT) && (r_hs_d != SYNC_ACT);
  // A line start wins over a coincident sample point.
  assign w_strobe  = (r_phase == PH_SAMPLE) && !w_hs_edge;
  assign w_blank   = (r_hs_s == SYNC_ACT) || (r_vs_s == SYNC_ACT);
  assign w_bar     = r_pix_cnt[BAR_LOG2+2:BAR_LOG2];

  always_comb begin
    w_col3 = '0;
    w_col3[IN_BITS-1:0] = r_col_hold;
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (io_pix.mode)
      2'b00: begin
        w_r = w_col3[0] ? ON_LEVEL : 4'h0;
        w_g = w_col3[0] ? ON_LEVEL : 4'h0;
        w_b = w_col3[0] ? ON_LEVEL : 4'h0;
      end
      2'b01: begin
        w_r = w_col3[0] ? ON_LEVEL : 4'h0;
        w_g = w_col3[1] ? ON_LEVEL : 4'h0;
        w_b = w_col3[2] ? ON_LEVEL : 4'h0;
      end
      2'b10: begin
        w_r = w_bar[0] ? ON_LEVEL : 4'h0;
        w_g = w_bar[1] ? ON_LEVEL : 4'h0;
        w_b = w_bar[2] ? ON_LEVEL : 4'h0;
      end
      default: ;
    endcase
    if (w_blank) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_meta  <= SYNC_INACT;
      r_hs_s     <= SYNC_INACT;
      r_hs_d     <= SYNC_INACT;
      r_vs_meta  <= SYNC_INACT;
      r_vs_s     <= SYNC_INACT;
      r_col_meta <= '0;
      r_col_s    <= '0;
    end else begin
      r_hs_meta  <= io_pix.rpi_h_sync;
      r_hs_s     <= r_hs_meta;
      r_hs_d     <= r_hs_s;
      r_vs_meta  <= io_pix.rpi_v_sync;
      r_vs_s     <= r_vs_meta;
      r_col_meta <= io_pix.rpi_color;
      r_col_s    <= r_col_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_pix_cnt  <= '0;
      r_col_hold <= '0;
    end else if (w_hs_edge) begin
      r_phase    <= '0;
      r_pix_cnt  <= '0;
    end else begin
      r_phase <= r_phase + PH_ONE;
      if (w_strobe) begin
        r_col_hold <= r_col_s;
        // Saturate so long lines park on the last bar instead of wrapping.
        if (r_pix_cnt != PIX_MAX) r_pix_cnt <= r_pix_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_out      <= '0;
      r_g_out      <= '0;
      r_b_out      <= '0;
      r_strobe_out <= 1'b0;
      r_h_out      <= SYNC_INACT;
      r_v_out      <= SYNC_INACT;
    end else begin
      r_r_out      <= w_r;
      r_g_out      <= w_g;
      r_b_out      <= w_b;
      r_strobe_out <= w_strobe;
      r_h_out      <= r_hs_s;
      r_v_out      <= r_vs_s;
    end
  end

  assign io_pix.r_out         = r_r_out;
  assign io_pix.g_out         = r_g_out;
  assign io_pix.b_out         = r_b_out;
  assign io_pix.sample_strobe = r_strobe_out;
  assign io_pix.h_sync        = r_h_out;
  assign io_pix.v_sync        = r_v_out;
endmodule

// File: tb/tb_rpi_pixel_sampler.sv
// Directed bench for rpi_pixel_sampler: mode table plus latency, blanking,
// reset and saturation sequences on a 3-bit and a 2-bit instance.
module tb_rpi_pixel_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rpi_pixel_sampler_if #(.IN_BITS(3)) if1 ();
  rpi_pixel_sampler_if #(.IN_BITS(2)) if2 ();

  assign if2.mode       = if1.mode;
  assign if2.rpi_h_sync = if1.rpi_h_sync;
  assign if2.rpi_v_sync = if1.rpi_v_sync;
  assign if2.rpi_color  = if1.rpi_color[1:0];

  rpi_pixel_sampler u_dut (.clk(clk), .rst(rst), .io_pix(if1));
  rpi_pixel_sampler #(.IN_BITS(2)) u_dut2 (.clk(clk), .rst(rst), .io_pix(if2));

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  col;
    logic [11:0] exp1;
    logic [11:0] exp2;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.sample_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [11:0] bar_rgb(input int n);
    logic [10:0] pix;
    logic [2:0]  bar;
    pix = (n > 2047) ? 11'd2047 : 11'(n);
    bar = pix[7:5];
    return {bar[0] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[2] ? 4'hF : 4'h0};
  endfunction

  initial begin
    bit ok;
    int n;

    vecs[0] = '{2'b00, 3'b001, 12'hFFF, 12'hFFF};
    vecs[1] = '{2'b00, 3'b000, 12'h000, 12'h000};
    vecs[2] = '{2'b00, 3'b110, 12'h000, 12'h000};
    vecs[3] = '{2'b01, 3'b101, 12'hF0F, 12'hF00};
    vecs[4] = '{2'b01, 3'b110, 12'h0FF, 12'h0F0};
    vecs[5] = '{2'b01, 3'b010, 12'h0F0, 12'h0F0};
    vecs[6] = '{2'b11, 3'b111, 12'h000, 12'h000};
    vecs[7] = '{2'b01, 3'b111, 12'hFFF, 12'hFF0};
    vecs[8] = '{2'b00, 3'b011, 12'hFFF, 12'hFFF};

    if1.mode       = 2'b00;
    if1.rpi_h_sync = 1'b1;
    if1.rpi_v_sync = 1'b1;
    if1.rpi_color  = 3'b001;

    // reset state, then first strobe SAMPLE_PHASE+1 cycles after release
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_rgb", {4'h0, if1.r_out, if1.g_out, if1.b_out}, 16'h0000);
    chk("reset_misc", {13'h0, if1.sample_strobe, if1.h_sync, if1.v_sync}, 16'h0003);
    rst = 1'b0;
    repeat (4) tick();
    chk("rel_strobe_early", {15'h0, if1.sample_strobe}, 16'h0000);
    tick();
    chk("rel_strobe_first", {15'h0, if1.sample_strobe}, 16'h0001);

    // mode / colour table
    for (int i = 0; i < 9; i++) begin
      if1.mode      = vecs[i].mode;
      if1.rpi_color = vecs[i].col;
      repeat (30) tick();
      chk($sformatf("vec%0d_in3", i), {4'h0, if1.r_out, if1.g_out, if1.b_out}, {4'h0, vecs[i].exp1});
      chk($sformatf("vec%0d_in2", i), {4'h0, if2.r_out, if2.g_out, if2.b_out}, {4'h0, vecs[i].exp2});
    end

    // vsync blanking window, lit mono
    if1.mode = 2'b00;
    if1.rpi_color = 3'b001;
    repeat (30) tick();
    if1.rpi_v_sync = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("blank_rgb_t%0d", i), {4'h0, if1.r_out, if1.g_out, if1.b_out},
          (i >= 3 && i <= 6) ? 16'h0000 : 16'h0FFF);
      chk($sformatf("blank_vs_t%0d", i), {15'h0, if1.v_sync},
          (i >= 3 && i <= 6) ? 16'h0000 : 16'h0001);
      if (i == 4) if1.rpi_v_sync = 1'b1;
    end

    // hsync latency: h_sync after 3 clocks, first strobe after 8
    repeat (10) tick();
    if1.rpi_h_sync = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("lat_hs_t%0d", i), {15'h0, if1.h_sync}, (i < 3) ? 16'h0001 : 16'h0000);
      if (i >= 3)
        chk($sformatf("lat_strobe_t%0d", i), {15'h0, if1.sample_strobe},
            (i == 8) ? 16'h0001 : 16'h0000);
    end
    if1.rpi_h_sync = 1'b1;
    repeat (10) tick();

    // hs_edge lands on phase==SAMPLE_PHASE: strobe suppressed, counters realign
    wait_strobe(ok);
    chk("coinc_wait", {15'h0, ok}, 16'h0001);
    repeat (5) tick();
    if1.rpi_h_sync = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("coinc_strobe_t%0d", i), {15'h0, if1.sample_strobe},
          (i == 8) ? 16'h0001 : 16'h0000);
    end
    if1.rpi_h_sync = 1'b1;
    repeat (10) tick();

    // async reset mid-line with outputs lit
    repeat (30) tick();
    chk("prerst_lit", {4'h0, if1.r_out, if1.g_out, if1.b_out}, 16'h0FFF);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rgb", {4'h0, if1.r_out, if1.g_out, if1.b_out}, 16'h0000);
    chk("midrst_misc", {13'h0, if1.sample_strobe, if1.h_sync, if1.v_sync}, 16'h0003);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("postrst_lit", {4'h0, if1.r_out, if1.g_out, if1.b_out}, 16'h0FFF);

    // colour bars and pixel counter saturation
    if1.mode = 2'b10;
    if1.rpi_h_sync = 1'b0;
    tick();
    tick();
    if1.rpi_h_sync = 1'b1;
    n = 0;
    while (n < 2100) begin
      wait_strobe(ok);
      if (!ok) begin
        chk("bars_strobe_timeout", 16'h0000, 16'h0001);
        break;
      end
      n++;
      tick();
      chk($sformatf("bars_n%0d", n), {4'h0, if1.r_out, if1.g_out, if1.b_out}, {4'h0, bar_rgb(n)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rpi_pixel_sampler.md
RPI_PIXEL_SAMPLER -- requirements
Module: rpi_pixel_sampler

Interface
REQ-001 Parameter IN_BITS, default 3; number of RPi colour input bits, legal range 1..3.
REQ-002 Parameter DIV_LOG2, default 3; the sample period is 2^DIV_LOG2 clk cycles, legal range 1..4.
REQ-003 Parameter SAMPLE_PHASE, default 4; the phase-counter value at which colour is sampled, legal range 0..2^DIV_LOG2-1.
REQ-004 Parameter SYNC_ACT, default 0; active level of the sync inputs and outputs.
REQ-005 Parameter ON_LEVEL, default 4'hF; the 4-bit output value driven for a lit channel.
REQ-006 Parameter BAR_LOG2, default 5; the test-pattern bar width is 2^BAR_LOG2 pixels.
REQ-007 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-008 clk  input  1  system clock; all state is sampled on the rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 mode  input  2  00 mono, 01 RGB111, 10 colour bars, 11 black; sampled with no synchroniser and quasi-static.
REQ-011 rpi_h_sync  input  1  asynchronous RPi horizontal sync.
REQ-012 rpi_v_sync  input  1  asynchronous RPi vertical sync.
REQ-013 rpi_color  input  IN_BITS  asynchronous RPi colour bits.
REQ-014 h_sync  output  1  horizontal sync, registered and latency-aligned to the colour outputs.
REQ-015 v_sync  output  1  vertical sync, registered and latency-aligned to the colour outputs.
REQ-016 r_out, g_out, b_out  output  4 each  registered DAC drive.
REQ-017 sample_strobe  output  1  single-cycle pulse marking the cycle in which colour is captured.

Function
REQ-018 Input synchronisation: rpi_h_sync, rpi_v_sync and rpi_color SHALL each pass through a 2-flop synchroniser; the resulting signals are hs_s, vs_s and col_s.
REQ-019 Line-start edge: hs_edge SHALL be 1 for one cycle when hs_s changes from inactive to active (SYNC_ACT).
REQ-020 Phase counter: the DIV_LOG2-bit phase counter SHALL load 0 when hs_edge=1, and otherwise increment modulo 2^DIV_LOG2 every cycle.
REQ-021 Strobe: the strobe SHALL be 1 when phase==SAMPLE_PHASE and hs_edge=0; hs_edge takes priority and suppresses the strobe in its cycle.
REQ-022 Colour capture: on a strobe, col_s SHALL be captured into col_hold; col_hold SHALL hold between strobes.
REQ-023 Pixel counter: the 11-bit pixel counter SHALL clear on hs_edge, increment on each strobe, and saturate at 2047 with no wrap.
REQ-024 Colour mapping, mode 00: all three channels = ON_LEVEL if col_hold[0]=1, else 0.
REQ-025 Colour mapping, mode 01: r from col_hold[0], g from col_hold[1], b from col_hold[2]; any bit at index >= IN_BITS reads as 0.
REQ-026 Colour mapping, mode 10: bar = pix_cnt[BAR_LOG2+2:BAR_LOG2]; r from bar[0], g from bar[1], b from bar[2], each mapped to ON_LEVEL or 0.
REQ-027 Colour mapping, mode 11: all channels = 0.
REQ-028 Blanking: while the delayed hs or delayed vs is active, r_out, g_out and b_out SHALL be 0, overriding every mode.
REQ-029 Output register: r_out, g_out, b_out and sample_strobe SHALL update one cycle after the strobe or state change that drives them.
REQ-030 Sync latency: h_sync and v_sync SHALL equal the raw inputs delayed by exactly 3 clk cycles (2 synchroniser stages plus 1 output register).
REQ-031 Sync edge cases: a sync pulse shorter than one clk cycle MAY be lost; the block SHALL never produce a multi-cycle glitch from it.
REQ-032 Mode change: a change to mode SHALL take effect on the next output-register update; no reset of counters is required.
REQ-033 Simultaneous events: hs_edge in the same cycle as phase==SAMPLE_PHASE SHALL reset both counters, with no capture.

Reset
REQ-034 While rst=1: synchronisers are driven to the inactive level (~SYNC_ACT), phase=0, pix_cnt=0, col_hold=0, r_out=g_out=b_out=0, sample_strobe=0, h_sync=v_sync=~SYNC_ACT.
REQ-035 Reset asserted mid-line SHALL clear state immediately (asynchronously); after release, the first strobe occurs SAMPLE_PHASE+1 cycles later, or at the next hs_edge alignment.
REQ-036 Outputs SHALL never be X or undriven after reset, in contrast to the undefined bit 3 of the previous design.

Verification
REQ-037 Latency: defaults; drive an hsync inactive-to-active edge at cycle T -> h_sync toggles at T+3, and the first sample_strobe appears at T+2+1+4+1.
REQ-038 Mono: mode=00, rpi_color=3'b001 steady, syncs inactive -> r_out=g_out=b_out=4'hF after the first strobe; rpi_color=0 -> all 4'h0.
REQ-039 RGB: mode=01, IN_BITS=2, rpi_color=2'b10 -> r_out=0, g_out=4'hF, b_out=0.
REQ-040 Bars: mode=10, BAR_LOG2=5; strobes 0..31 give black; strobes 32..63 give r=4'hF only; pix_cnt holds at 2047 beyond 2047 strobes.
REQ-041 Blanking: rpi_v_sync active while colour is lit -> all channels 0 for the delayed sync window; colour resumes on the first cycle after the window.
REQ-042 Reset: assert rst for 1 cycle mid-line with outputs lit -> every output reaches its reset value in the same cycle, with no X after release.
